// File: rtl/falu_arbiter.sv
// Round-robin arbiter/sequencer sharing one falu among N requesters.
// Latches the winner's operands, starts the ALU, waits with a watchdog and returns a one-cycle response.
module falu_arbiter #(
    parameter int N       = 2,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    input  logic [32*N-1:0]   req_op_a,
    input  logic [32*N-1:0]   req_op_b,
    input  logic [2*N-1:0]    req_op_code,
    input  logic [N-1:0]      req_mode_fp,
    input  logic [N-1:0]      req_round_mode,
    output logic [N-1:0]      gnt,
    output logic              rsp_valid,
    output logic [1:0]        rsp_id,
    output logic [31:0]       rsp_result,
    output logic [4:0]        rsp_flags,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              alu_start,
    output logic              alu_clr,
    output logic [31:0]       alu_op_a,
    output logic [31:0]       alu_op_b,
    output logic [1:0]        alu_op_code,
    output logic              alu_mode_fp,
    output logic              alu_round_mode,
    input  logic [31:0]       alu_result,
    input  logic [4:0]        alu_flags,
    input  logic              alu_valid
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
    localparam logic [1:0] LAST_ID = 2'(N - 1);

    logic [1:0]   state;
    logic [1:0]   ptr;
    logic [1:0]   winner;
    logic [7:0]   wd_cnt;

    logic         pick_vld;
    logic [1:0]   pick_idx;
    logic [31:0]  sel_a;
    logic [31:0]  sel_b;
    logic [1:0]   sel_code;
    logic         sel_mf;
    logic         sel_rm;
    logic [N-1:0] gnt_nxt;
    logic         first_wait;
    logic [1:0]   ptr_nxt;

    // Two passes give the rotated search: indices at/after ptr first, then the wrap-around.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int j = 0; j < N; j++) begin
            if (!pick_vld && req[j] && (j >= int'(ptr))) begin
                pick_vld = 1'b1;
                pick_idx = 2'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!pick_vld && req[j]) begin
                pick_vld = 1'b1;
                pick_idx = 2'(j);
            end
        end
    end

    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        sel_code = '0;
        sel_mf   = 1'b0;
        sel_rm   = 1'b0;
        gnt_nxt  = '0;
        for (int j = 0; j < N; j++) begin
            if (pick_idx == 2'(j)) begin
                sel_a      = req_op_a[32*j +: 32];
                sel_b      = req_op_b[32*j +: 32];
                sel_code   = req_op_code[2*j +: 2];
                sel_mf     = req_mode_fp[j];
                sel_rm     = req_round_mode[j];
                gnt_nxt[j] = 1'b1;
            end
        end
    end

    // A valid level left over from the previous op is still visible in the first WAIT cycle.
    assign first_wait = (wd_cnt == 8'd0);
    assign ptr_nxt    = (winner == LAST_ID) ? 2'd0 : winner + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            ptr            <= '0;
            winner         <= '0;
            wd_cnt         <= '0;
            gnt            <= '0;
            rsp_valid      <= 1'b0;
            rsp_id         <= '0;
            rsp_result     <= '0;
            rsp_flags      <= '0;
            rsp_timeout    <= 1'b0;
            busy           <= 1'b0;
            alu_start      <= 1'b0;
            alu_clr        <= 1'b0;
            alu_op_a       <= '0;
            alu_op_b       <= '0;
            alu_op_code    <= '0;
            alu_mode_fp    <= 1'b0;
            alu_round_mode <= 1'b0;
        end else begin
            gnt       <= '0;
            alu_start <= 1'b0;
            alu_clr   <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        winner         <= pick_idx;
                        alu_op_a       <= sel_a;
                        alu_op_b       <= sel_b;
                        alu_op_code    <= sel_code;
                        alu_mode_fp    <= sel_mf;
                        alu_round_mode <= sel_rm;
                        gnt            <= gnt_nxt;
                        alu_start      <= 1'b1;
                        busy           <= 1'b1;
                        state          <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wd_cnt <= '0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (!first_wait && alu_valid) begin
                        rsp_result  <= alu_result;
                        rsp_flags   <= alu_flags;
                        rsp_timeout <= 1'b0;
                        rsp_id      <= winner;
                        rsp_valid   <= 1'b1;
                        state       <= S_RESP;
                    end else if (wd_cnt == WD_LAST) begin
                        rsp_result  <= '0;
                        rsp_flags   <= '0;
                        rsp_timeout <= 1'b1;
                        rsp_id      <= winner;
                        rsp_valid   <= 1'b1;
                        alu_clr     <= 1'b1;
                        state       <= S_RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end
                default: begin
                    ptr   <= ptr_nxt;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_falu_arbiter.sv
// Scoreboard bench for falu_arbiter: a reference arbiter and an ALU model drive
// expectations into queues that a negedge monitor drains.
module tb_falu_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req;
    logic [32*N-1:0]   req_op_a;
    logic [32*N-1:0]   req_op_b;
    logic [2*N-1:0]    req_op_code;
    logic [N-1:0]      req_mode_fp;
    logic [N-1:0]      req_round_mode;
    logic [N-1:0]      gnt;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [31:0]       rsp_result;
    logic [4:0]        rsp_flags;
    logic              rsp_timeout;
    logic              busy;
    logic              alu_start;
    logic              alu_clr;
    logic [31:0]       alu_op_a;
    logic [31:0]       alu_op_b;
    logic [1:0]        alu_op_code;
    logic              alu_mode_fp;
    logic              alu_round_mode;
    logic [31:0]       alu_result = '0;
    logic [4:0]        alu_flags  = '0;
    logic              alu_valid  = 1'b0;

    falu_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req),
        .req_op_a(req_op_a), .req_op_b(req_op_b), .req_op_code(req_op_code),
        .req_mode_fp(req_mode_fp), .req_round_mode(req_round_mode),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout),
        .busy(busy), .alu_start(alu_start), .alu_clr(alu_clr),
        .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_op_code(alu_op_code),
        .alu_mode_fp(alu_mode_fp), .alu_round_mode(alu_round_mode),
        .alu_result(alu_result), .alu_flags(alu_flags), .alu_valid(alu_valid)
    );

    always #5 clk = ~clk;

    logic [31:0] op_a [N];
    logic [31:0] op_b [N];
    logic [1:0]  op_code [N];
    logic        op_mf [N];
    logic        op_rm [N];

    always_comb begin
        req_op_a       = '0;
        req_op_b       = '0;
        req_op_code    = '0;
        req_mode_fp    = '0;
        req_round_mode = '0;
        for (int i = 0; i < N; i++) begin
            req_op_a[32*i +: 32]  = op_a[i];
            req_op_b[32*i +: 32]  = op_b[i];
            req_op_code[2*i +: 2] = op_code[i];
            req_mode_fp[i]        = op_mf[i];
            req_round_mode[i]     = op_rm[i];
        end
    end

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  code;
        logic        mf;
        logic        rm;
        logic [31:0] res;
        logic [4:0]  flg;
        logic        to;
        int          lat;
    } exp_t;

    exp_t gnt_q[$];
    exp_t rsp_q[$];

    int checks = 0;
    int errs   = 0;
    int cyc    = 0;
    int gnt_cyc = 0;
    int mptr   = 0;
    int cur_lat = 3;
    bit level_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Bench-side ALU behaviour: {flags, result}
    function automatic logic [36:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] code, input logic mf, input logic rm);
        logic [31:0] r;
        logic [4:0]  f;
        if (a == 32'h3F80_0000 && b == 32'h4000_0000 && code == 2'd0) begin
            r = 32'h4040_0000;
            f = 5'd0;
        end else begin
            r = (a + b) ^ {mf, rm, 28'd0, code};
            f = a[4:0] ^ b[9:5] ^ {3'd0, code};
        end
        return {f, r};
    endfunction

    // ALU model: valid appears k cycles after start; cur_lat==0 means it never answers.
    int          pend = 0;
    logic [36:0] pres = '0;
    always @(negedge clk) begin
        if (rst) begin
            pend = 0;
            alu_valid = 1'b0;
        end else begin
            if (alu_clr) begin
                pend = 0;
                alu_valid = 1'b0;
            end
            if (!level_mode) alu_valid = 1'b0;
            if (pend > 0) begin
                pend = pend - 1;
                if (pend == 0) begin
                    alu_valid  = 1'b1;
                    alu_result = pres[31:0];
                    alu_flags  = pres[36:32];
                end
            end
            if (alu_start) begin
                pend = cur_lat;
                pres = alu_fn(alu_op_a, alu_op_b, alu_op_code, alu_mode_fp, alu_round_mode);
            end
        end
    end

    exp_t m;
    always @(negedge clk) begin
        if (!rst) begin
            if (gnt != '0) begin
                if (gnt_q.size() == 0) begin
                    chk("stray_gnt", 64'(gnt), 64'd0);
                end else begin
                    m = gnt_q.pop_front();
                    chk("gnt", 64'(gnt), 64'd1 << m.id);
                    chk("alu_start", 64'(alu_start), 64'd1);
                    chk("busy_issue", 64'(busy), 64'd1);
                    chk("alu_op_a", 64'(alu_op_a), 64'(m.a));
                    chk("alu_op_b", 64'(alu_op_b), 64'(m.b));
                    chk("alu_op_code", 64'(alu_op_code), 64'(m.code));
                    chk("alu_modes", 64'({alu_mode_fp, alu_round_mode}), 64'({m.mf, m.rm}));
                    gnt_cyc = cyc;
                end
            end else if (alu_start) begin
                chk("start_without_gnt", 64'(alu_start), 64'd0);
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("stray_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    m = rsp_q.pop_front();
                    chk("rsp_id", 64'(rsp_id), 64'(m.id));
                    chk("rsp_result", 64'(rsp_result), 64'(m.res));
                    chk("rsp_flags", 64'(rsp_flags), 64'(m.flg));
                    chk("rsp_timeout", 64'(rsp_timeout), 64'(m.to));
                    chk("alu_clr", 64'(alu_clr), 64'(m.to));
                    chk("gnt_to_rsp", 64'(cyc - gnt_cyc), 64'(m.lat));
                    chk("busy_resp", 64'(busy), 64'd1);
                end
            end else if (alu_clr) begin
                chk("stray_alu_clr", 64'(alu_clr), 64'd0);
            end
        end
    end

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            op_a[i]    = $urandom;
            op_b[i]    = $urandom;
            op_code[i] = 2'($urandom_range(0, 3));
            op_mf[i]   = 1'($urandom_range(0, 1));
            op_rm[i]   = 1'($urandom_range(0, 1));
        end
    endtask

    // Reference arbiter: first requester at or after mptr in circular order.
    task automatic issue_op(input logic [N-1:0] pat, input int lat, output int waited);
        int w;
        int k;
        exp_t s;
        logic [36:0] r;
        w = -1;
        for (int i = 0; i < N; i++) begin
            k = (mptr + i) % N;
            if (w < 0 && pat[k[1:0]]) w = k;
        end
        s.id   = w;
        s.a    = op_a[w];
        s.b    = op_b[w];
        s.code = op_code[w];
        s.mf   = op_mf[w];
        s.rm   = op_rm[w];
        r      = alu_fn(s.a, s.b, s.code, s.mf, s.rm);
        s.to   = (lat == 0);
        s.res  = s.to ? 32'd0 : r[31:0];
        s.flg  = s.to ? 5'd0 : r[36:32];
        s.lat  = s.to ? TIMEOUT + 1 : lat + 1;
        mptr   = (w + 1) % N;
        gnt_q.push_back(s);
        rsp_q.push_back(s);
        cur_lat = lat;
        req = pat;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (gnt == '0 && waited < 200);
        if (gnt == '0) chk("gnt_wait_expired", 64'(waited), 64'd0);
        @(posedge clk);
        #1;
        req = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((rsp_q.size() != 0 || busy) && n < 100);
        if (rsp_q.size() != 0 || busy) begin
            chk("idle_wait_expired", 64'(rsp_q.size()), 64'd0);
            rsp_q.delete();
            gnt_q.delete();
        end
    endtask

    initial begin
        int wt;
        int lat;
        logic [N-1:0] pat;
        req = '0;
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0; op_b[i] = '0; op_code[i] = '0; op_mf[i] = 1'b0; op_rm[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_alu_start", 64'(alu_start), 64'd0);
        chk("rst_alu_clr", 64'(alu_clr), 64'd0);
        chk("rst_alu_op_a", 64'(alu_op_a), 64'd0);
        chk("rst_rsp_result", 64'({rsp_id, rsp_flags, rsp_timeout}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // single op: 1.0 + 2.0
        rand_ops();
        op_a[0] = 32'h3F80_0000; op_b[0] = 32'h4000_0000; op_code[0] = 2'd0;
        issue_op(4'b0001, 3, wt);
        chk("req_to_gnt", 64'(wt), 64'd1);
        wait_idle();

        // rotation with a continuously held request set
        for (int i = 0; i < 5; i++) begin
            rand_ops();
            issue_op(4'b0111, 2 + i, wt);
        end
        wait_idle();

        // wrap from the last requester back to 0
        rand_ops(); issue_op(4'b0100, 2, wt);
        rand_ops(); issue_op(4'b1001, 3, wt);
        rand_ops(); issue_op(4'b1001, 2, wt);
        wait_idle();

        // watchdog expiry, then a normal op afterwards
        rand_ops(); issue_op(4'b0010, 0, wt);
        wait_idle();
        rand_ops(); issue_op(4'b0001, 2, wt);
        wait_idle();

        // valid held as a level across ops
        level_mode = 1'b1;
        rand_ops(); issue_op(4'b0100, 3, wt);
        rand_ops(); issue_op(4'b0100, 2, wt);
        rand_ops(); issue_op(4'b1000, 2, wt);
        wait_idle();
        level_mode = 1'b0;
        rand_ops(); issue_op(4'b0001, 2, wt);
        wait_idle();

        // asynchronous reset in the middle of WAIT
        rand_ops(); issue_op(4'b0100, 6, wt);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_gnt", 64'(gnt), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_alu_op_a", 64'(alu_op_a), 64'd0);
        chk("midrst_rsp_result", 64'(rsp_result), 64'd0);
        chk("midrst_ctrl", 64'({rsp_valid, alu_start, alu_clr, rsp_timeout, rsp_id}), 64'd0);
        req = '0;
        rsp_q.delete();
        gnt_q.delete();
        mptr = 0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (12) @(negedge clk);
        rand_ops(); issue_op(4'b1111, 2, wt);
        chk("post_rst_req_to_gnt", 64'(wt), 64'd1);
        wait_idle();

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            rand_ops();
            pat = 4'($urandom_range(1, 15));
            lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(2, 7));
            if ($urandom_range(0, 3) == 0) begin
                wait_idle();
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            issue_op(pat, lat, wt);
        end
        wait_idle();
        repeat (4) @(negedge clk);
        chk("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
        chk("gnt_queue_drained", 64'(gnt_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
